axi4_lite_slave: RTL and testbench
==================================

AXI4_LITE_SLAVE -- requirements
Module: axi4_lite_slave

Interface
REQ-001 SHALL have parameter AXI_ADDR_WIDTH, default 64, meaning address bus width.
REQ-002 SHALL have parameter AXI_DATA_WIDTH, default 32, meaning data bus width (32 or 64).
REQ-003 SHALL have parameter MEM_DEPTH, default 64, meaning number of data words in local storage.
REQ-004 SHALL have ports:
- clk  input  1  single clock; all logic rising-edge.
- arst  input  1  asynchronous, active-low reset.
- AW_VALID/AW_READY  input/output  1  write-address handshake.
- AW_ADDR  input  AXI_ADDR_WIDTH  write address.
- AW_PROT  input  3  accepted, ignored.
- W_VALID/W_READY  input/output  1  write-data handshake.
- W_DATA  input  AXI_DATA_WIDTH  write data.
- W_STRB  input  AXI_DATA_WIDTH/8  byte strobes.
- B_VALID/B_READY  output/input  1  write-response handshake.
- B_RESP  output  2  write response.
- AR_VALID/AR_READY  input/output  1  read-address handshake.
- AR_ADDR  input  AXI_ADDR_WIDTH  read address.
- AR_PROT  input  3  accepted, ignored.
- R_VALID/R_READY  output/input  1  read-data handshake.
- R_DATA  output  AXI_DATA_WIDTH  read data.
- R_RESP  output  2  read response.

Function
REQ-005 Word index SHALL be address >> log2(AXI_DATA_WIDTH/8); low byte-offset bits ignored.
REQ-006 Index >= MEM_DEPTH SHALL be out of range: response SLVERR (2'b10), no storage write, R_DATA = 0; in range gives OKAY (2'b00).
REQ-007 Write FSM SHALL have states W_IDLE, W_WAIT_DATA (addr held), W_WAIT_ADDR (data held), W_RESP.
REQ-008 AW_READY SHALL be 1 in W_IDLE and W_WAIT_ADDR only; W_READY SHALL be 1 in W_IDLE and W_WAIT_DATA only.
REQ-009 AW and W handshakes SHALL be accepted in either order or in the same cycle; the captured address/data/strobe are registered.
REQ-010 Storage SHALL be written on the clock edge where the second of the two handshakes completes; FSM moves to W_RESP with B_VALID=1 the next cycle.
REQ-011 B_VALID and B_RESP SHALL hold stable until B_READY=1; on that edge FSM returns to W_IDLE (no new AW/W accepted while in W_RESP).
REQ-012 Read FSM SHALL have states R_IDLE, R_RESP; AR_READY=1 only in R_IDLE.
REQ-013 On AR handshake, R_DATA/R_RESP SHALL be registered and R_VALID=1 the next cycle (latency 1); held stable until R_READY=1, then R_IDLE.
REQ-014 Read and write channels SHALL operate concurrently; a read and write to the same word completing on the same edge SHALL return the old data.
REQ-015 B_VALID and R_VALID SHALL never depend combinationally on B_READY/R_READY.

Reset
REQ-016 While arst=0: both FSMs idle, B_VALID=0, R_VALID=0, B_RESP=0, R_RESP=0, R_DATA=0; AW_READY/W_READY/AR_READY take their idle values (1) after arst is released.
REQ-017 Reset mid-transaction SHALL abandon it with no storage write; storage contents SHALL be cleared to zero.

Configuration
REQ-018 With AXI4_LITE_SLAVE_STRB_EN defined, only bytes whose W_STRB bit is 1 SHALL be written; without it, W_STRB SHALL be ignored and full words written.

Structure
REQ-019 Package axi4_lite_pkg SHALL hold response codes (RESP_OKAY, RESP_SLVERR) and the write/read state enum typedefs.
REQ-020 Storage SHALL be sub-module axi4_lite_slave_mem (one write port with byte enables, one registered-address read port, async clear).

Verification
REQ-021 AW and W same cycle, addr 0x8, data 0xDEADBEEF, strobe 4'hF -> B_VALID next cycle, B_RESP=0; read 0x8 -> R_DATA=0xDEADBEEF, R_RESP=0, one cycle after AR.
REQ-022 W three cycles before AW (addr 0x10, data 0x12345678) -> W_READY low after W accept, single write on AW accept, B_RESP=0.
REQ-023 Write/read addr 0x100 (index 64) -> B_RESP=2'b10, R_RESP=2'b10, R_DATA=0, word 0 unchanged.
REQ-024 With AXI4_LITE_SLAVE_STRB_EN: write 0xFFFFFFFF then 0x000000AA strobe 4'b0001 -> read 0xFFFFFFAA; without macro -> 0x000000AA.
REQ-025 B_READY/R_READY held low 5 cycles -> B_VALID/R_VALID and payloads stable, AW/AR_READY low throughout.
REQ-026 arst=0 asserted during W_WAIT_DATA -> B_VALID=0, no write; all words read 0 afterwards.

Source files
------------

// File: rtl/axi4_lite_slave_pkg.sv
// Shared response codes, FSM state types and helpers for the AXI4-Lite slave.
package axi4_lite_pkg;

    localparam logic [1:0] RESP_OKAY   = 2'b00;
    localparam logic [1:0] RESP_SLVERR = 2'b10;

    typedef enum logic [1:0] {
        W_IDLE      = 2'd0,
        W_WAIT_DATA = 2'd1,
        W_WAIT_ADDR = 2'd2,
        W_RESP      = 2'd3
    } wr_state_e;

    typedef enum logic {
        R_IDLE = 1'b0,
        R_RESP = 1'b1
    } rd_state_e;

    function automatic logic [1:0] resp_code(input logic hit);
        return hit ? RESP_OKAY : RESP_SLVERR;
    endfunction

endpackage

// File: rtl/axi4_lite_slave_if.sv
// AXI4-Lite bus bundle between a master and axi4_lite_slave.
interface axi4_lite_slave_if #(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32
);
    logic                          AW_VALID;
    logic                          AW_READY;
    logic [AXI_ADDR_WIDTH-1:0]     AW_ADDR;
    logic [2:0]                    AW_PROT;
    logic                          W_VALID;
    logic                          W_READY;
    logic [AXI_DATA_WIDTH-1:0]     W_DATA;
    logic [AXI_DATA_WIDTH/8-1:0]   W_STRB;
    logic                          B_VALID;
    logic                          B_READY;
    logic [1:0]                    B_RESP;
    logic                          AR_VALID;
    logic                          AR_READY;
    logic [AXI_ADDR_WIDTH-1:0]     AR_ADDR;
    logic [2:0]                    AR_PROT;
    logic                          R_VALID;
    logic                          R_READY;
    logic [AXI_DATA_WIDTH-1:0]     R_DATA;
    logic [1:0]                    R_RESP;

    modport slave (
        input  AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY,
               AR_VALID, AR_ADDR, AR_PROT, R_READY,
        output AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
    );

    modport master (
        output AW_VALID, AW_ADDR, AW_PROT, W_VALID, W_DATA, W_STRB, B_READY,
               AR_VALID, AR_ADDR, AR_PROT, R_READY,
        input  AW_READY, W_READY, B_VALID, B_RESP, AR_READY, R_VALID, R_DATA, R_RESP
    );

endinterface

// File: rtl/axi4_lite_slave_mem.sv
// Word storage: byte-enabled write port, registered read port, asynchronous clear.
module axi4_lite_slave_mem #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic                clk,
    input  logic                arst,
    input  logic                wr_en_i,
    input  logic [IDX_W-1:0]    wr_idx_i,
    input  logic [DATA_W-1:0]   wr_data_i,
    input  logic [DATA_W/8-1:0] wr_be_i,
    input  logic                rd_en_i,
    input  logic                rd_hit_i,
    input  logic [IDX_W-1:0]    rd_idx_i,
    output logic [DATA_W-1:0]   rd_data_o
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [DATA_W-1:0] rd_data_q;

    // storage array: cleared by reset, written byte-wise
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_q[i] <= '0;
            end
        end else if (wr_en_i) begin
            for (int b = 0; b < DATA_W/8; b++) begin
                if (wr_be_i[b]) begin
                    mem_q[wr_idx_i][8*b +: 8] <= wr_data_i[8*b +: 8];
                end
            end
        end
    end

    // read register samples pre-write contents, so a same-edge write returns old data
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            rd_data_q <= '0;
        end else if (rd_en_i) begin
            rd_data_q <= rd_hit_i ? mem_q[rd_idx_i] : '0;
        end else begin
            rd_data_q <= rd_data_q;
        end
    end

    assign rd_data_o = rd_data_q;

endmodule

// File: rtl/axi4_lite_slave.sv
// AXI4-Lite slave with local word storage; define AXI4_LITE_SLAVE_STRB_EN to honour
// W_STRB byte strobes (otherwise full words are always written).
module axi4_lite_slave
    import axi4_lite_pkg::*;
#(
    parameter int AXI_ADDR_WIDTH = 64,
    parameter int AXI_DATA_WIDTH = 32,
    parameter int MEM_DEPTH      = 64
) (
    input  logic            clk,
    input  logic            arst,
    axi4_lite_slave_if.slave bus
);

    localparam int NUM_BYTES = AXI_DATA_WIDTH / 8;
    localparam int OFF_W     = $clog2(NUM_BYTES);
    localparam int IDX_W     = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
    localparam logic [AXI_ADDR_WIDTH-1:0] DEPTH_A = AXI_ADDR_WIDTH'(MEM_DEPTH);

    wr_state_e                   wr_state_q;
    logic [AXI_ADDR_WIDTH-1:0]   aw_addr_q;
    logic [AXI_DATA_WIDTH-1:0]   w_data_q;
    logic [NUM_BYTES-1:0]        w_strb_q;
    logic                        aw_ready_q;
    logic                        w_ready_q;
    logic                        b_valid_q;
    logic [1:0]                  b_resp_q;

    rd_state_e                   rd_state_q;
    logic                        ar_ready_q;
    logic                        r_valid_q;
    logic [1:0]                  r_resp_q;

    logic                        aw_hs_s;
    logic                        w_hs_s;
    logic                        ar_hs_s;
    logic                        wr_fire_s;
    logic [AXI_ADDR_WIDTH-1:0]   wr_addr_s;
    logic [AXI_DATA_WIDTH-1:0]   wr_data_s;
    logic [NUM_BYTES-1:0]        wr_strb_s;
    logic [NUM_BYTES-1:0]        wr_be_s;
    logic [AXI_ADDR_WIDTH-1:0]   wr_word_s;
    logic                        wr_hit_s;
    logic [AXI_ADDR_WIDTH-1:0]   rd_word_s;
    logic                        rd_hit_s;
    logic [AXI_DATA_WIDTH-1:0]   r_data_s;
    logic                        unused_s;

    assign aw_hs_s = bus.AW_VALID && aw_ready_q;
    assign w_hs_s  = bus.W_VALID  && w_ready_q;
    assign ar_hs_s = bus.AR_VALID && ar_ready_q;

    // select the address/data pair that completes a write on this edge
    always_comb begin
        wr_fire_s = 1'b0;
        wr_addr_s = aw_addr_q;
        wr_data_s = w_data_q;
        wr_strb_s = w_strb_q;
        case (wr_state_q)
            W_IDLE: begin
                if (aw_hs_s && w_hs_s) begin
                    wr_fire_s = 1'b1;
                    wr_addr_s = bus.AW_ADDR;
                    wr_data_s = bus.W_DATA;
                    wr_strb_s = bus.W_STRB;
                end else begin
                    wr_fire_s = 1'b0;
                end
            end
            W_WAIT_DATA: begin
                if (w_hs_s) begin
                    wr_fire_s = 1'b1;
                    wr_data_s = bus.W_DATA;
                    wr_strb_s = bus.W_STRB;
                end else begin
                    wr_fire_s = 1'b0;
                end
            end
            W_WAIT_ADDR: begin
                if (aw_hs_s) begin
                    wr_fire_s = 1'b1;
                    wr_addr_s = bus.AW_ADDR;
                end else begin
                    wr_fire_s = 1'b0;
                end
            end
            default: begin
                wr_fire_s = 1'b0;
            end
        endcase
    end

    assign wr_word_s = wr_addr_s >> OFF_W;
    assign wr_hit_s  = wr_word_s < DEPTH_A;
    assign rd_word_s = bus.AR_ADDR >> OFF_W;
    assign rd_hit_s  = rd_word_s < DEPTH_A;

`ifdef AXI4_LITE_SLAVE_STRB_EN
    assign wr_be_s = wr_strb_s;
`else
    assign wr_be_s = '1;
`endif

    assign unused_s = ^{bus.AW_PROT, bus.AR_PROT, wr_strb_s};

    // write-channel FSM with registered handshake outputs
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            wr_state_q <= W_IDLE;
            aw_addr_q  <= '0;
            w_data_q   <= '0;
            w_strb_q   <= '0;
            aw_ready_q <= 1'b1;
            w_ready_q  <= 1'b1;
            b_valid_q  <= 1'b0;
            b_resp_q   <= RESP_OKAY;
        end else if (wr_fire_s) begin
            wr_state_q <= W_RESP;
            aw_addr_q  <= wr_addr_s;
            w_data_q   <= wr_data_s;
            w_strb_q   <= wr_strb_s;
            aw_ready_q <= 1'b0;
            w_ready_q  <= 1'b0;
            b_valid_q  <= 1'b1;
            b_resp_q   <= resp_code(wr_hit_s);
        end else begin
            case (wr_state_q)
                W_IDLE: begin
                    if (aw_hs_s) begin
                        wr_state_q <= W_WAIT_DATA;
                        aw_addr_q  <= bus.AW_ADDR;
                        aw_ready_q <= 1'b0;
                    end else if (w_hs_s) begin
                        wr_state_q <= W_WAIT_ADDR;
                        w_data_q   <= bus.W_DATA;
                        w_strb_q   <= bus.W_STRB;
                        w_ready_q  <= 1'b0;
                    end else begin
                        wr_state_q <= W_IDLE;
                    end
                end
                W_WAIT_DATA, W_WAIT_ADDR: begin
                    wr_state_q <= wr_state_q;
                end
                W_RESP: begin
                    if (bus.B_READY) begin
                        wr_state_q <= W_IDLE;
                        aw_ready_q <= 1'b1;
                        w_ready_q  <= 1'b1;
                        b_valid_q  <= 1'b0;
                    end else begin
                        wr_state_q <= W_RESP;
                    end
                end
                default: begin
                    wr_state_q <= W_IDLE;
                    aw_ready_q <= 1'b1;
                    w_ready_q  <= 1'b1;
                    b_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    // read-channel FSM; data comes from the storage read register
    always_ff @(posedge clk or negedge arst) begin
        if (!arst) begin
            rd_state_q <= R_IDLE;
            ar_ready_q <= 1'b1;
            r_valid_q  <= 1'b0;
            r_resp_q   <= RESP_OKAY;
        end else begin
            case (rd_state_q)
                R_IDLE: begin
                    if (ar_hs_s) begin
                        rd_state_q <= R_RESP;
                        ar_ready_q <= 1'b0;
                        r_valid_q  <= 1'b1;
                        r_resp_q   <= resp_code(rd_hit_s);
                    end else begin
                        rd_state_q <= R_IDLE;
                    end
                end
                R_RESP: begin
                    if (bus.R_READY) begin
                        rd_state_q <= R_IDLE;
                        ar_ready_q <= 1'b1;
                        r_valid_q  <= 1'b0;
                    end else begin
                        rd_state_q <= R_RESP;
                    end
                end
                default: begin
                    rd_state_q <= R_IDLE;
                    ar_ready_q <= 1'b1;
                    r_valid_q  <= 1'b0;
                end
            endcase
        end
    end

    axi4_lite_slave_mem #(
        .DATA_W (AXI_DATA_WIDTH),
        .DEPTH  (MEM_DEPTH),
        .IDX_W  (IDX_W)
    ) u_mem (
        .clk       (clk),
        .arst      (arst),
        .wr_en_i   (wr_fire_s && wr_hit_s),
        .wr_idx_i  (wr_word_s[IDX_W-1:0]),
        .wr_data_i (wr_data_s),
        .wr_be_i   (wr_be_s),
        .rd_en_i   (ar_hs_s),
        .rd_hit_i  (rd_hit_s),
        .rd_idx_i  (rd_word_s[IDX_W-1:0]),
        .rd_data_o (r_data_s)
    );

    assign bus.AW_READY = aw_ready_q;
    assign bus.W_READY  = w_ready_q;
    assign bus.B_VALID  = b_valid_q;
    assign bus.B_RESP   = b_resp_q;
    assign bus.AR_READY = ar_ready_q;
    assign bus.R_VALID  = r_valid_q;
    assign bus.R_DATA   = r_data_s;
    assign bus.R_RESP   = r_resp_q;

endmodule

// File: tb/tb_axi4_lite_slave.sv
// Scoreboard bench for axi4_lite_slave: expected responses queued at stimulus time,
// popped and compared when B/R beats appear.
module tb_axi4_lite_slave;
    import axi4_lite_pkg::*;

    localparam int AW    = 64;
    localparam int DW    = 32;
    localparam int DEPTH = 64;

    logic clk  = 1'b0;
    logic arst = 1'b1;
    always #5 clk = ~clk;

    axi4_lite_slave_if #(.AXI_ADDR_WIDTH(AW), .AXI_DATA_WIDTH(DW)) bus ();

    axi4_lite_slave #(
        .AXI_ADDR_WIDTH (AW),
        .AXI_DATA_WIDTH (DW),
        .MEM_DEPTH      (DEPTH)
    ) dut (
        .clk  (clk),
        .arst (arst),
        .bus  (bus)
    );

    int          checks = 0;
    int          errors = 0;
    logic [31:0] model [DEPTH];
    logic [1:0]  b_q [$];
    logic [33:0] r_q [$];

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
        end
    endtask

    task automatic model_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s);
        logic [63:0] w;
        logic [3:0]  m;
        w = a >> 2;
`ifdef AXI4_LITE_SLAVE_STRB_EN
        m = s;
`else
        m = s | 4'hF;
`endif
        if (w < 64'(DEPTH)) begin
            for (int b = 0; b < 4; b++) begin
                if (m[b]) model[w[5:0]][8*b +: 8] = d[8*b +: 8];
            end
            b_q.push_back(RESP_OKAY);
        end else begin
            b_q.push_back(RESP_SLVERR);
        end
    endtask

    task automatic expect_read(input logic [63:0] a);
        logic [63:0] w;
        w = a >> 2;
        if (w < 64'(DEPTH)) r_q.push_back({RESP_OKAY, model[w[5:0]]});
        else                r_q.push_back({RESP_SLVERR, 32'h0000_0000});
    endtask

    task automatic wait_b(input string tag);
        int         n;
        logic [1:0] e;
        n = 0;
        @(negedge clk);
        while (bus.B_VALID !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_bvalid"}, 64'(bus.B_VALID), 64'd1);
        check_eq({tag, "_bsb"}, 64'(b_q.size() > 0), 64'd1);
        e = (b_q.size() > 0) ? b_q.pop_front() : 2'b11;
        check_eq({tag, "_bresp"}, 64'(bus.B_RESP), 64'(e));
        bus.B_READY = 1'b1;
        @(posedge clk);
        #1;
        bus.B_READY = 1'b0;
    endtask

    task automatic wait_r(input string tag);
        int          n;
        logic [33:0] e;
        n = 0;
        @(negedge clk);
        while (bus.R_VALID !== 1'b1 && n < 20) begin
            @(negedge clk);
            n++;
        end
        check_eq({tag, "_rvalid"}, 64'(bus.R_VALID), 64'd1);
        check_eq({tag, "_rsb"}, 64'(r_q.size() > 0), 64'd1);
        e = (r_q.size() > 0) ? r_q.pop_front() : {2'b11, 32'hFFFF_FFFF};
        check_eq({tag, "_rdata"}, 64'(bus.R_DATA), 64'(e[31:0]));
        check_eq({tag, "_rresp"}, 64'(bus.R_RESP), 64'(e[33:32]));
        bus.R_READY = 1'b1;
        @(posedge clk);
        #1;
        bus.R_READY = 1'b0;
    endtask

    // AW and W together; leaves the response pending
    task automatic issue_write(input logic [63:0] a, input logic [31:0] d, input logic [3:0] s);
        model_write(a, d, s);
        bus.AW_VALID = 1'b1; bus.AW_ADDR = a;
        bus.W_VALID  = 1'b1; bus.W_DATA  = d; bus.W_STRB = s;
        @(posedge clk);
        #1;
        bus.AW_VALID = 1'b0;
        bus.W_VALID  = 1'b0;
        check_eq("b_latency", 64'(bus.B_VALID), 64'd1);
    endtask

    task automatic do_write(input string tag, input logic [63:0] a, input logic [31:0] d,
                            input logic [3:0] s);
        issue_write(a, d, s);
        wait_b(tag);
    endtask

    task automatic do_read(input string tag, input logic [63:0] a);
        expect_read(a);
        bus.AR_VALID = 1'b1; bus.AR_ADDR = a;
        @(posedge clk);
        #1;
        bus.AR_VALID = 1'b0;
        check_eq({tag, "_rlat"}, 64'(bus.R_VALID), 64'd1);
        wait_r(tag);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        bus.AW_VALID = 1'b0; bus.AW_ADDR = '0; bus.AW_PROT = 3'b000;
        bus.W_VALID  = 1'b0; bus.W_DATA  = '0; bus.W_STRB  = 4'h0;
        bus.B_READY  = 1'b0;
        bus.AR_VALID = 1'b0; bus.AR_ADDR = '0; bus.AR_PROT = 3'b000;
        bus.R_READY  = 1'b0;
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;

        #1 arst = 1'b0;
        #2;
        check_eq("rst_bvalid", 64'(bus.B_VALID), 64'd0);
        check_eq("rst_rvalid", 64'(bus.R_VALID), 64'd0);
        check_eq("rst_bresp",  64'(bus.B_RESP),  64'd0);
        check_eq("rst_rresp",  64'(bus.R_RESP),  64'd0);
        check_eq("rst_rdata",  64'(bus.R_DATA),  64'd0);
        #9 arst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("idle_awready", 64'(bus.AW_READY), 64'd1);
        check_eq("idle_wready",  64'(bus.W_READY),  64'd1);
        check_eq("idle_arready", 64'(bus.AR_READY), 64'd1);

        // same-cycle AW/W then read back
        do_write("w_same", 64'h8, 32'hDEAD_BEEF, 4'hF);
        do_read("r_same", 64'h8);
        do_read("r_lowbits", 64'hB);

        // W three cycles ahead of AW
        model_write(64'h10, 32'h1234_5678, 4'hF);
        bus.W_VALID = 1'b1; bus.W_DATA = 32'h1234_5678; bus.W_STRB = 4'hF;
        @(posedge clk);
        #1;
        bus.W_VALID = 1'b0;
        check_eq("wfirst_wready", 64'(bus.W_READY), 64'd0);
        check_eq("wfirst_awready", 64'(bus.AW_READY), 64'd1);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk);
            #1;
            check_eq("wfirst_nob", 64'(bus.B_VALID), 64'd0);
        end
        bus.AW_VALID = 1'b1; bus.AW_ADDR = 64'h10;
        @(posedge clk);
        #1;
        bus.AW_VALID = 1'b0;
        check_eq("wfirst_blat", 64'(bus.B_VALID), 64'd1);
        wait_b("wfirst");
        do_read("r_wfirst", 64'h10);

        // AW ahead of W
        model_write(64'h14, 32'h0F0F_1234, 4'hF);
        bus.AW_VALID = 1'b1; bus.AW_ADDR = 64'h14;
        @(posedge clk);
        #1;
        bus.AW_VALID = 1'b0;
        check_eq("awfirst_awready", 64'(bus.AW_READY), 64'd0);
        check_eq("awfirst_wready",  64'(bus.W_READY),  64'd1);
        @(posedge clk);
        #1;
        bus.W_VALID = 1'b1; bus.W_DATA = 32'h0F0F_1234; bus.W_STRB = 4'hF;
        @(posedge clk);
        #1;
        bus.W_VALID = 1'b0;
        wait_b("awfirst");
        do_read("r_awfirst", 64'h14);

        // range boundaries
        do_write("w_word0", 64'h0, 32'h1122_3344, 4'hF);
        do_write("w_idx63", 64'hFC, 32'hA5A5_5A5A, 4'hF);
        do_write("w_oor", 64'h100, 32'h5555_5555, 4'hF);
        do_write("w_oor_hi", 64'h1_0000_0000, 32'h6666_6666, 4'hF);
        do_read("r_oor", 64'h100);
        do_read("r_word0", 64'h0);
        do_read("r_idx63", 64'hFC);

        // byte strobes
        do_write("w_ones", 64'h20, 32'hFFFF_FFFF, 4'hF);
        do_write("w_strb", 64'h20, 32'h0000_00AA, 4'b0001);
        do_read("r_strb", 64'h20);

        // response back-pressure
        issue_write(64'h30, 32'hCAFE_F00D, 4'hF);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_bvalid",  64'(bus.B_VALID),  64'd1);
            check_eq("bp_bresp",   64'(bus.B_RESP),   64'd0);
            check_eq("bp_awready", 64'(bus.AW_READY), 64'd0);
            check_eq("bp_wready",  64'(bus.W_READY),  64'd0);
        end
        @(posedge clk);
        #1;
        wait_b("bp_w");
        expect_read(64'h30);
        bus.AR_VALID = 1'b1; bus.AR_ADDR = 64'h30;
        @(posedge clk);
        #1;
        bus.AR_VALID = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check_eq("bp_rvalid",  64'(bus.R_VALID),  64'd1);
            check_eq("bp_rdata",   64'(bus.R_DATA),   64'hCAFE_F00D);
            check_eq("bp_arready", 64'(bus.AR_READY), 64'd0);
        end
        @(posedge clk);
        #1;
        wait_r("bp_r");

        // read and write of the same word on the same edge return old data
        expect_read(64'h8);
        model_write(64'h8, 32'h0BAD_F00D, 4'hF);
        bus.AR_VALID = 1'b1; bus.AR_ADDR = 64'h8;
        bus.AW_VALID = 1'b1; bus.AW_ADDR = 64'h8;
        bus.W_VALID  = 1'b1; bus.W_DATA  = 32'h0BAD_F00D; bus.W_STRB = 4'hF;
        @(posedge clk);
        #1;
        bus.AR_VALID = 1'b0; bus.AW_VALID = 1'b0; bus.W_VALID = 1'b0;
        wait_b("coll_w");
        wait_r("coll_r");
        do_read("r_coll_new", 64'h8);

        // reset while holding an address in W_WAIT_DATA
        bus.AW_VALID = 1'b1; bus.AW_ADDR = 64'h8;
        @(posedge clk);
        #1;
        bus.AW_VALID = 1'b0;
        check_eq("mid_awready", 64'(bus.AW_READY), 64'd0);
        check_eq("mid_wready",  64'(bus.W_READY),  64'd1);
        bus.W_DATA = 32'h7777_7777;
        #2 arst = 1'b0;
        #1;
        check_eq("mid_rst_bvalid", 64'(bus.B_VALID), 64'd0);
        check_eq("mid_rst_rdata",  64'(bus.R_DATA),  64'd0);
        for (int i = 0; i < DEPTH; i++) model[i] = 32'h0;
        @(negedge clk);
        arst = 1'b1;
        @(posedge clk);
        #1;
        check_eq("post_rst_awready", 64'(bus.AW_READY), 64'd1);
        check_eq("post_rst_wready",  64'(bus.W_READY),  64'd1);
        check_eq("post_rst_bvalid",  64'(bus.B_VALID),  64'd0);
        for (int i = 0; i < DEPTH; i++) begin
            do_read("r_clear", 64'(i * 4));
        end

        check_eq("sb_drain", 64'(b_q.size() + r_q.size()), 64'd0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
